// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencing for a five-stage core: per-stage enables/flushes for load-use,
// taken-branch and multi-cycle data-memory hazards, with a timed memReady handshake.
module pipeline_hazard_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             memRead_Ex,
    input  logic [4:0]       rd_Ex,
    input  logic [4:0]       rs1_Id,
    input  logic [4:0]       rs2_Id,
    input  logic             rs1Used_Id,
    input  logic             rs2Used_Id,
    input  logic             branchTaken_Ex,
    input  logic             memAccess_Mem,
    input  logic             memReady,
    output logic             dmemReq,
    output logic             pcEn,
    output logic             ifIdEn,
    output logic             ifIdFlush,
    output logic             idExEn,
    output logic             idExFlush,
    output logic             exMemEn,
    output logic             memWbFlush,
    output logic             memTimeoutErr,
    output logic [CNT_W-1:0] stallCycles
);

    // state    | meaning
    // RUN      | pipeline flowing; hazards resolved combinationally
    // MEM_WAIT | data access outstanding, pipeline frozen, wait counter running
    // ERROR    | memReady never arrived; everything frozen until reset
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            r_state, w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_mem_stall, w_load_use;
    logic w_pc_en, w_if_id_en, w_if_id_flush, w_id_ex_en, w_id_ex_flush;
    logic w_ex_mem_en, w_mem_wb_flush, w_dmem_req, w_err;

    assign w_mem_stall = memAccess_Mem & ~memReady;
    assign w_load_use  = memRead_Ex & (rd_Ex != 5'd0) &
                         ((rs1Used_Id & (rs1_Id == rd_Ex)) |
                          (rs2Used_Id & (rs2_Id == rd_Ex)));

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (!w_pc_en && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_pc_en        = 1'b1;
        w_if_id_en     = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_en     = 1'b1;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_en    = 1'b1;
        w_mem_wb_flush = 1'b0;
        w_dmem_req     = 1'b0;
        w_err          = 1'b0;

        case (r_state)
            RUN, MEM_WAIT: begin
                w_dmem_req = memAccess_Mem;
                if (w_mem_stall) begin
                    w_pc_en        = 1'b0;
                    w_if_id_en     = 1'b0;
                    w_id_ex_en     = 1'b0;
                    w_ex_mem_en    = 1'b0;
                    w_mem_wb_flush = 1'b1;
                end else if (branchTaken_Ex) begin
                    // wrong-path ID instruction is squashed, so loadUse is moot
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                end else if (w_load_use) begin
                    w_pc_en       = 1'b0;
                    w_if_id_en    = 1'b0;
                    w_id_ex_flush = 1'b1;
                end

                if (r_state == RUN) begin
                    if (w_mem_stall) begin
                        w_state_nxt    = MEM_WAIT;
                        w_wait_cnt_nxt = WAIT_W'(1);
                    end
                end else if (!memAccess_Mem || memReady) begin
                    w_state_nxt    = RUN;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_state_nxt = ERROR;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
                end
            end
            default: begin
                w_pc_en     = 1'b0;
                w_if_id_en  = 1'b0;
                w_id_ex_en  = 1'b0;
                w_ex_mem_en = 1'b0;
                w_err       = 1'b1;
            end
        endcase
    end

    assign pcEn          = w_pc_en;
    assign ifIdEn        = w_if_id_en;
    assign ifIdFlush     = w_if_id_flush;
    assign idExEn        = w_id_ex_en;
    assign idExFlush     = w_id_ex_flush;
    assign exMemEn       = w_ex_mem_en;
    assign memWbFlush    = w_mem_wb_flush;
    assign dmemReq       = w_dmem_req;
    assign memTimeoutErr = w_err;
    assign stallCycles   = r_stall_cnt;

endmodule
